// File: rtl/button_conditioner_if.sv
// Button bus between the raw board pins and the brush stage.
// The master drives KEY_RAW. The slave (the conditioner) drives the clean level and the edge pulses.
interface button_conditioner_if #(
  parameter int unsigned BTN_NUM = 4
);

  logic [BTN_NUM-1:0] KEY_RAW;
  logic [BTN_NUM-1:0] BTN;
  logic [BTN_NUM-1:0] BTN_POSEDGE;
  logic [BTN_NUM-1:0] BTN_NEGEDGE;

  modport master (
    output KEY_RAW,
    input  BTN,
    input  BTN_POSEDGE,
    input  BTN_NEGEDGE
  );

  modport slave (
    input  KEY_RAW,
    output BTN,
    output BTN_POSEDGE,
    output BTN_NEGEDGE
  );

endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser and debouncer for the paint controls.
// Produces registered clean levels and one-cycle press/release pulses.
module button_conditioner #(
  parameter int unsigned BTN_NUM         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW_IN   = 1'b1,
  parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  localparam logic [0:0]           STABLE_LO = 1'b0;
  localparam logic [0:0]           STABLE_HI = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [BTN_NUM-1:0]   IDLE_RAW  = {BTN_NUM{ACTIVE_LOW_IN}};

  logic [BTN_NUM-1:0]   sync_q1;
  logic [BTN_NUM-1:0]   sync_q2;
  logic [BTN_NUM-1:0]   sync;

  logic [BTN_NUM-1:0]   state_q;
  logic [BTN_NUM-1:0]   state_d;
  logic [CNT_WIDTH-1:0] cnt_q [BTN_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [BTN_NUM];
  logic [BTN_NUM-1:0]   pos_q;
  logic [BTN_NUM-1:0]   pos_d;
  logic [BTN_NUM-1:0]   neg_q;
  logic [BTN_NUM-1:0]   neg_d;

  // Two-flop synchroniser; reset parks it at the released pin level
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1 <= IDLE_RAW;
      sync_q2 <= IDLE_RAW;
    end else begin
      sync_q1 <= bus.KEY_RAW;
      sync_q2 <= sync_q1;
    end
  end

  // Normalise polarity so that 1 always means pressed
  assign sync = sync_q2 ^ IDLE_RAW;

  // Debounce state, counters and pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      for (int i = 0; i < int'(BTN_NUM); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      for (int i = 0; i < int'(BTN_NUM); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-channel next state: any cycle of agreement restarts the count
  always_comb begin
    state_d = state_q;
    pos_d   = '0;
    neg_d   = '0;
    for (int i = 0; i < int'(BTN_NUM); i++) begin
      cnt_d[i] = cnt_q[i];
    end

    for (int i = 0; i < int'(BTN_NUM); i++) begin
      if (sync[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CNT_LAST) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else begin
        cnt_d[i] = '0;
        if (state_q[i] == STABLE_LO) begin
          state_d[i] = STABLE_HI;
          pos_d[i]   = 1'b1;
        end else begin
          state_d[i] = STABLE_LO;
          neg_d[i]   = 1'b1;
        end
      end
    end
  end

  assign bus.BTN         = state_q;
  assign bus.BTN_POSEDGE = pos_q;
  assign bus.BTN_NEGEDGE = neg_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: an active-low and an active-high instance with a short debounce.
// Expectations are queued with their due cycle and are compared when that cycle arrives.
module tb_button_conditioner;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  typedef struct {
    int unsigned cyc;
    bit          hi;
    logic [11:0] val;
    logic [63:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [11:0] obs;
  int unsigned c0;
  int unsigned s;
  int unsigned r;

  button_conditioner_if #(.BTN_NUM(N)) ba ();
  button_conditioner_if #(.BTN_NUM(N)) bh ();

  button_conditioner #(
    .BTN_NUM(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ba)
  );

  button_conditioner #(
    .BTN_NUM(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1'b0)
  ) dut_h (
    .clk(clk), .reset(reset), .bus(bh)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int unsigned at, input bit hi, input logic [3:0] b,
                           input logic [3:0] p, input logic [3:0] n, input logic [63:0] tag);
    sb.push_back('{at, hi, {b, p, n}, tag});
  endtask

  // Compare every expectation that is due this cycle
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs = sb[i].hi ? {bh.BTN, bh.BTN_POSEDGE, bh.BTN_NEGEDGE}
                       : {ba.BTN, ba.BTN_POSEDGE, ba.BTN_NEGEDGE};
        checks++;
        assert (obs === sb[i].val) else begin
          errors++;
          $error("FAIL %s cyc=%0d btn/pos/neg observed=%b expected=%b",
                 sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    ba.KEY_RAW  = 4'b1111;
    bh.KEY_RAW  = 4'b0000;
    tick(1);
    expect_at(cyc + 1, 1'b0, 4'b0000, 4'b0000, 4'b0000, "rst_a");
    expect_at(cyc + 1, 1'b1, 4'b0000, 4'b0000, 4'b0000, "rst_h");
    tick(2);
    reset = 1'b1;
    tick(3);

    // Clean press on channel 0
    c0 = cyc;
    ba.KEY_RAW[0] = 1'b0;
    expect_at(c0 + 5, 1'b0, 4'b0000, 4'b0000, 4'b0000, "cp_pre");
    expect_at(c0 + 6, 1'b0, 4'b0001, 4'b0001, 4'b0000, "cp_edge");
    expect_at(c0 + 7, 1'b0, 4'b0001, 4'b0000, 4'b0000, "cp_post");
    for (int k = 8; k <= 12; k++)
      expect_at(c0 + k, 1'b0, 4'b0001, 4'b0000, 4'b0000, "held");
    tick(13);

    // Bounce on channel 1: low 3, high 1, low 2, high 1, then held low
    s = cyc;
    for (int k = 1; k <= 16; k++)
      expect_at(s + k, 1'b0, (k >= 13) ? 4'b0011 : 4'b0001,
                (k == 13) ? 4'b0010 : 4'b0000, 4'b0000, "bounce");
    ba.KEY_RAW[1] = 1'b0; tick(3);
    ba.KEY_RAW[1] = 1'b1; tick(1);
    ba.KEY_RAW[1] = 1'b0; tick(2);
    ba.KEY_RAW[1] = 1'b1; tick(1);
    ba.KEY_RAW[1] = 1'b0;
    tick(10);

    // Release channel 0
    c0 = cyc;
    ba.KEY_RAW[0] = 1'b1;
    for (int k = 1; k <= 8; k++)
      expect_at(c0 + k, 1'b0, (k >= 6) ? 4'b0010 : 4'b0011, 4'b0000,
                (k == 6) ? 4'b0001 : 4'b0000, "release");
    tick(10);

    // Simultaneous press on channels 3 and 2
    c0 = cyc;
    ba.KEY_RAW[3:2] = 2'b00;
    expect_at(c0 + 5, 1'b0, 4'b0010, 4'b0000, 4'b0000, "sim_pre");
    expect_at(c0 + 6, 1'b0, 4'b1110, 4'b1100, 4'b0000, "sim_edge");
    expect_at(c0 + 7, 1'b0, 4'b1110, 4'b0000, 4'b0000, "sim_post");
    tick(10);

    // Reset mid-debounce on channel 0, with all keys held through reset
    c0 = cyc;
    ba.KEY_RAW[0] = 1'b0;
    for (int k = 1; k <= 4; k++)
      expect_at(c0 + k, 1'b0, 4'b1110, 4'b0000, 4'b0000, "rst_pre");
    for (int k = 5; k <= 7; k++) begin
      expect_at(c0 + k, 1'b0, 4'b0000, 4'b0000, 4'b0000, "rst_mid");
      expect_at(c0 + k, 1'b1, 4'b0000, 4'b0000, 4'b0000, "rst_midh");
    end
    tick(4);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    r = cyc;
    for (int k = 1; k <= 5; k++)
      expect_at(r + k, 1'b0, 4'b0000, 4'b0000, 4'b0000, "rst_rel");
    expect_at(r + 6, 1'b0, 4'b1111, 4'b1111, 4'b0000, "rst_held");
    expect_at(r + 7, 1'b0, 4'b1111, 4'b0000, 4'b0000, "rst_post");
    tick(10);

    // Active-high instance: press and release channel 2
    c0 = cyc;
    bh.KEY_RAW[2] = 1'b1;
    expect_at(c0 + 5, 1'b1, 4'b0000, 4'b0000, 4'b0000, "ah_pre");
    expect_at(c0 + 6, 1'b1, 4'b0100, 4'b0100, 4'b0000, "ah_edge");
    expect_at(c0 + 7, 1'b1, 4'b0100, 4'b0000, 4'b0000, "ah_post");
    tick(10);
    c0 = cyc;
    bh.KEY_RAW[2] = 1'b0;
    expect_at(c0 + 5, 1'b1, 4'b0100, 4'b0000, 4'b0000, "ah_rpre");
    expect_at(c0 + 6, 1'b1, 4'b0000, 4'b0000, 4'b0100, "ah_rel");
    expect_at(c0 + 7, 1'b1, 4'b0000, 4'b0000, 4'b0000, "ah_rpost");
    tick(10);

    // Any expectation left over was never reached
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage for the paint controls.
- Takes raw board push-buttons (asynchronous, bouncing, optionally active-low) and produces clean levels plus single-cycle edge pulses.
- Output buses drive the brush stage's BTN and BTN_POSEDGE inputs directly.
- One independent synchroniser + debounce channel per button.

Parameters:
- BTN_NUM, 4: number of button channels.
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised input must differ from the debounced level before the level changes (10 ms at 50 MHz). Legal range ≥ 2.
- ACTIVE_LOW_IN, 1: 1 = raw pins read 0 when pressed (inverted at input); 0 = active-high pins.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES): width of each per-channel counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous and active-low.
- KEY_RAW  input  BTN_NUM  raw asynchronous button pins.
- BTN  output  BTN_NUM  debounced level, 1 = pressed.
- BTN_POSEDGE  output  BTN_NUM  one-cycle pulse on debounced press.
- BTN_NEGEDGE  output  BTN_NUM  one-cycle pulse on debounced release.

Behaviour:
- **Reset** (sampled low on a clk edge):
  - Both synchroniser stages load the inactive raw level (all 1s if ACTIVE_LOW_IN, else 0s).
  - Counters load 0.
  - BTN, BTN_POSEDGE and BTN_NEGEDGE load 0.
  - Reset mid-debounce discards the partial count; no pulse is emitted.
- **Input conditioning:**
  - Per channel: two-flop synchroniser on KEY_RAW.
  - sync = sync_q2 XOR ACTIVE_LOW_IN, giving 1 = pressed.
  - sync_q2 reflects a pin change after 2 clk edges.
- **Per-channel FSM:** two states, STABLE_LO (BTN=0) and STABLE_HI (BTN=1).
  - If sync equals the current state: counter clears to 0.
  - If sync differs and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If sync differs and counter == DEBOUNCE_CYCLES-1: state toggles and counter clears on that edge.
- **Glitch rejection:** any single cycle of agreement with the current state restarts the count. A bounce shorter than DEBOUNCE_CYCLES never changes BTN.
- **Edge pulses:**
  - Registered, asserted on the same edge that toggles BTN, high for exactly one cycle.
  - BTN_POSEDGE[i] fires on the LO→HI toggle; BTN_NEGEDGE[i] fires on the HI→LO toggle.
  - A channel can never assert both pulses in one cycle.
- **Latency:** a clean pin transition at edge 0 appears on BTN and the pulse at edge 2+DEBOUNCE_CYCLES.
- **Channel independence:** channels are fully independent. Simultaneous presses on several channels yield pulses in the same cycle with no arbitration.
- **Held button:**
  - Level stays 1; no repeat pulses.
  - The counter stays at 0 while sync matches the state, so it never wraps.
- **Held through reset:** a button held across reset release is reported as a new press (BTN=1 + BTN_POSEDGE) 2+DEBOUNCE_CYCLES cycles after release.
- **Output timing:** all outputs are registered. There are no combinational paths from KEY_RAW to any output.

Test Plan:
- **Clean press:** DEBOUNCE_CYCLES=4, ACTIVE_LOW_IN=1, reset released, KEY_RAW=4'b1111. Drive KEY_RAW[0]=0 at edge 0 → BTN=4'b0001 and BTN_POSEDGE=4'b0001 at edge 6. BTN_POSEDGE=0 at edge 7; BTN stays 1.
- **Bounce rejection:** toggle KEY_RAW[1] low/high with runs of 3,1,2 cycles, then hold low. BTN[1] rises only 6 edges after the final low hold begins, with exactly one BTN_POSEDGE[1] pulse.
- **Release:** from BTN[0]=1, drive KEY_RAW[0]=1 → BTN[0]=0 and BTN_NEGEDGE[0]=1 for one cycle 6 edges later. BTN_POSEDGE stays 0 throughout.
- **Simultaneous channels:** press KEY_RAW[3] and KEY_RAW[2] on the same edge → BTN_POSEDGE=4'b1100 in a single cycle, 6 edges later.
- **Reset mid-debounce:** press KEY_RAW[0], assert reset at debounce count 2, release reset with the key still held → no pulse during reset. BTN[0] rises 6 edges after reset release.
- **Active-high build:** ACTIVE_LOW_IN=0, KEY_RAW idles 0, set KEY_RAW[2]=1 → BTN[2]=1 and BTN_POSEDGE[2] pulse at edge 6.
